// File: rtl/krnl_ctrl_multi_chan_if.sv
// Control/handshake bundle between the SDx control slave, the sequencer and its engines.
// Perf counter signals appear only when KRNL_CTRL_PERF_CNT_EN is defined.
`timescale 1ns/1ps
interface krnl_ctrl_multi_chan_if #(
    parameter int unsigned C_NUM_CHANNELS    = 4,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32
);
    logic                         ap_start;
    logic                         ap_continue;
    logic                         ap_idle;
    logic                         ap_done;
    logic                         ap_ready;
    logic [C_NUM_CHANNELS-1:0]    ctrl_ch_enable;
    logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes;
    logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size_in_bytes;
    logic [C_NUM_CHANNELS-1:0]    ch_start;
    logic [C_NUM_CHANNELS-1:0]    ch_done;

`ifdef KRNL_CTRL_PERF_CNT_EN
    logic                         perf_clear;
    logic [63:0]                  perf_cycles;

    modport slave (
        input  ap_start, ap_continue, ctrl_ch_enable, ctrl_xfer_size_in_bytes, ch_done, perf_clear,
        output ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start, perf_cycles
    );
    modport master (
        output ap_start, ap_continue, ctrl_ch_enable, ctrl_xfer_size_in_bytes, ch_done, perf_clear,
        input  ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start, perf_cycles
    );
`else
    modport slave (
        input  ap_start, ap_continue, ctrl_ch_enable, ctrl_xfer_size_in_bytes, ch_done,
        output ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start
    );
    modport master (
        output ap_start, ap_continue, ctrl_ch_enable, ctrl_xfer_size_in_bytes, ch_done,
        input  ap_idle, ap_done, ap_ready, ch_xfer_size_in_bytes, ch_start
    );
`endif
endinterface

// File: rtl/krnl_ctrl_multi_chan.sv
// Kernel control sequencer: turns ap_start into per-channel start pulses and aggregates channel done.
// Define KRNL_CTRL_PERF_CNT_EN to add the perf_cycles run-length counter.
`timescale 1ns/1ps
module krnl_ctrl_multi_chan #(
    parameter int unsigned C_NUM_CHANNELS       = 4,
    parameter int unsigned C_XFER_SIZE_WIDTH    = 32,
    parameter int unsigned C_DEFAULT_XFER_BYTES = 16384,
    parameter int unsigned C_CHAIN_MODE         = 0
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    krnl_ctrl_multi_chan_if.slave ctrl
);
    localparam int unsigned   NCH      = C_NUM_CHANNELS;
    localparam int unsigned   SW       = C_XFER_SIZE_WIDTH;
    localparam logic [SW-1:0] DEF_SIZE = SW'(C_DEFAULT_XFER_BYTES);
    localparam bit            CHAIN    = (C_CHAIN_MODE != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ap_start_r;
    logic           start_pulse;
    logic           accept;
    logic [NCH-1:0] mask_q;
    logic [NCH-1:0] sticky_q;
    logic [NCH-1:0] sticky_nxt;
    logic [NCH-1:0] ch_done_q;
    logic [NCH-1:0] done_seen;
    logic [SW-1:0]  size_q;
    logic [SW-1:0]  size_sel;
    logic           ap_idle_q;
    logic           ap_done_q;
    logic           ap_ready_q;
    logic [NCH-1:0] ch_start_q;

    assign start_pulse = ctrl.ap_start & ~ap_start_r;
    assign size_sel    = (ctrl.ctrl_xfer_size_in_bytes == '0) ? DEF_SIZE
                                                             : ctrl.ctrl_xfer_size_in_bytes;
    // Engine done is retimed once, so completion lands two cycles after the final done.
    assign done_seen   = sticky_q | (ch_done_q & mask_q);

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        sticky_nxt = sticky_q;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    state_nxt  = S_START;
                    accept     = 1'b1;
                    sticky_nxt = '0;
                end
            end
            S_START: begin
                state_nxt = (mask_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                sticky_nxt = done_seen;
                if (done_seen == mask_q) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!CHAIN || ctrl.ap_continue) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Run parameters are captured only at acceptance and held for the whole run.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            ap_start_r <= 1'b0;
            ch_done_q  <= '0;
            sticky_q   <= '0;
            mask_q     <= '0;
            size_q     <= DEF_SIZE;
        end else begin
            ap_start_r <= ctrl.ap_start;
            ch_done_q  <= ctrl.ch_done;
            sticky_q   <= sticky_nxt;
            if (accept) begin
                mask_q <= ctrl.ctrl_ch_enable;
                size_q <= size_sel;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            ap_idle_q  <= 1'b1;
            ap_done_q  <= 1'b0;
            ap_ready_q <= 1'b0;
            ch_start_q <= '0;
        end else begin
            ap_idle_q  <= (state_nxt == S_IDLE);
            ap_done_q  <= (state_nxt == S_DONE);
            ap_ready_q <= accept;
            ch_start_q <= accept ? ctrl.ctrl_ch_enable : '0;
        end
    end

    assign ctrl.ap_idle               = ap_idle_q;
    assign ctrl.ap_done               = ap_done_q;
    assign ctrl.ap_ready              = ap_ready_q;
    assign ctrl.ch_start              = ch_start_q;
    assign ctrl.ch_xfer_size_in_bytes = size_q;

`ifdef KRNL_CTRL_PERF_CNT_EN
    logic [63:0] perf_q;

    // Counts START+RUN cycles of the current run; frozen in DONE and IDLE.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            perf_q <= '0;
        end else if (accept || ctrl.perf_clear) begin
            perf_q <= '0;
        end else if ((state == S_START) || (state == S_RUN)) begin
            perf_q <= perf_q + 64'd1;
        end
    end

    assign ctrl.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_krnl_ctrl_multi_chan.sv
// Bench: an hs and a chain controller share one stimulus stream and are checked each cycle
// against a run-level model (accept edge, outstanding channels, completion edge).
`timescale 1ns/1ps
module tb_krnl_ctrl_multi_chan;
    localparam int unsigned NCH = 4;
    localparam int unsigned SW  = 32;
    localparam logic [SW-1:0] DEF = SW'(16384);

    logic           ap_clk = 1'b0;
    logic           areset = 1'b0;
    logic           st     = 1'b0;
    logic           cont   = 1'b0;
    logic [NCH-1:0] en     = '0;
    logic [NCH-1:0] dn     = '0;
    logic [SW-1:0]  sz     = '0;

    int checks   = 0;
    int errors   = 0;
    bit mon_en   = 1'b0;
    int rdy_cnt  = 0;
    int done_cnt = 0;

    always #5 ap_clk = ~ap_clk;

    krnl_ctrl_multi_chan_if #(.C_NUM_CHANNELS(NCH), .C_XFER_SIZE_WIDTH(SW)) ifc0 ();
    krnl_ctrl_multi_chan_if #(.C_NUM_CHANNELS(NCH), .C_XFER_SIZE_WIDTH(SW)) ifc1 ();

    krnl_ctrl_multi_chan #(
        .C_NUM_CHANNELS(NCH), .C_XFER_SIZE_WIDTH(SW),
        .C_DEFAULT_XFER_BYTES(16384), .C_CHAIN_MODE(0)
    ) dut_hs (.ap_clk(ap_clk), .areset(areset), .ctrl(ifc0));

    krnl_ctrl_multi_chan #(
        .C_NUM_CHANNELS(NCH), .C_XFER_SIZE_WIDTH(SW),
        .C_DEFAULT_XFER_BYTES(16384), .C_CHAIN_MODE(1)
    ) dut_chain (.ap_clk(ap_clk), .areset(areset), .ctrl(ifc1));

    assign ifc0.ap_start = st;  assign ifc1.ap_start = st;
    assign ifc0.ap_continue = cont;  assign ifc1.ap_continue = cont;
    assign ifc0.ctrl_ch_enable = en;  assign ifc1.ctrl_ch_enable = en;
    assign ifc0.ctrl_xfer_size_in_bytes = sz;  assign ifc1.ctrl_xfer_size_in_bytes = sz;
    assign ifc0.ch_done = dn;  assign ifc1.ch_done = dn;

    logic           o_idle[2];
    logic           o_done[2];
    logic           o_ready[2];
    logic [NCH-1:0] o_chs[2];
    logic [SW-1:0]  o_size[2];
    assign o_idle[0] = ifc0.ap_idle;   assign o_idle[1] = ifc1.ap_idle;
    assign o_done[0] = ifc0.ap_done;   assign o_done[1] = ifc1.ap_done;
    assign o_ready[0] = ifc0.ap_ready; assign o_ready[1] = ifc1.ap_ready;
    assign o_chs[0] = ifc0.ch_start;   assign o_chs[1] = ifc1.ch_start;
    assign o_size[0] = ifc0.ch_xfer_size_in_bytes;
    assign o_size[1] = ifc1.ch_xfer_size_in_bytes;

`ifdef KRNL_CTRL_PERF_CNT_EN
    logic        pclr = 1'b0;
    logic [63:0] o_perf[2];
    logic [63:0] mperf[2];
    assign ifc0.perf_clear = pclr;  assign ifc1.perf_clear = pclr;
    assign o_perf[0] = ifc0.perf_cycles;  assign o_perf[1] = ifc1.perf_cycles;
`endif

    // Run-level model: edge index of acceptance, channels still owed, edge where the last one was seen.
    int             cyc = 0;
    bit             sprev;
    bit             busy[2];
    int             acc[2];
    int             zedge[2];
    logic [NCH-1:0] mmask[2];
    logic [NCH-1:0] rem[2];
    logic [SW-1:0]  msize[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic model_reset();
        sprev = 1'b0;
        for (int d = 0; d < 2; d++) begin
            busy[d]  = 1'b0;
            acc[d]   = 0;
            zedge[d] = -1;
            mmask[d] = '0;
            rem[d]   = '0;
            msize[d] = DEF;
`ifdef KRNL_CTRL_PERF_CNT_EN
            mperf[d] = '0;
`endif
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!busy[d]) begin
                if (st && !sprev) begin
                    busy[d]  = 1'b1;
                    acc[d]   = cyc;
                    mmask[d] = en;
                    rem[d]   = en;
                    msize[d] = (sz == '0) ? DEF : sz;
                    zedge[d] = (en == '0) ? cyc : -1;
                end
            end else if (cyc > acc[d]) begin
                if (zedge[d] < 0) begin
                    rem[d] = rem[d] & ~dn;
                    if (rem[d] == '0) zedge[d] = cyc;
                end else if (cyc >= zedge[d] + 2 && (d == 0 || cont)) begin
                    busy[d] = 1'b0;
                end
            end
`ifdef KRNL_CTRL_PERF_CNT_EN
            if ((busy[d] && acc[d] == cyc) || pclr) mperf[d] = '0;
            else if (busy[d] && cyc - 1 >= acc[d] && (zedge[d] < 0 || cyc - 1 <= zedge[d]))
                mperf[d] = mperf[d] + 64'd1;
`endif
        end
        sprev = st;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge ap_clk or posedge areset);
            if (areset) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    logic exp_ready;
                    exp_ready = busy[d] && (acc[d] == cyc);
                    chk($sformatf("ap_idle[%0d]", d), 64'(o_idle[d]), 64'(!busy[d]));
                    chk($sformatf("ap_ready[%0d]", d), 64'(o_ready[d]), 64'(exp_ready));
                    chk($sformatf("ch_start[%0d]", d), 64'(o_chs[d]),
                        64'(exp_ready ? mmask[d] : '0));
                    chk($sformatf("ap_done[%0d]", d), 64'(o_done[d]),
                        64'(busy[d] && zedge[d] >= 0 && cyc >= zedge[d] + 1));
                    chk($sformatf("xfer_size[%0d]", d), 64'(o_size[d]), 64'(msize[d]));
`ifdef KRNL_CTRL_PERF_CNT_EN
                    chk($sformatf("perf[%0d]", d), o_perf[d], mperf[d]);
`endif
                end
                if (o_ready[0] === 1'b1) rdy_cnt++;
                if (o_done[0] === 1'b1)  done_cnt++;
            end
        end
    end

    initial begin
        int r0;
        int d0;
        #1 areset = 1'b1;
        #2 mon_en = 1'b1;
        tick(2);
        chk("rst_idle", 64'(ifc0.ap_idle), 64'd1);
        chk("rst_done", 64'(ifc0.ap_done), 64'd0);
        chk("rst_ready", 64'(ifc0.ap_ready), 64'd0);
        chk("rst_chs", 64'(ifc0.ch_start), 64'd0);
        chk("rst_size", 64'(ifc0.ch_xfer_size_in_bytes), 64'd16384);
        areset = 1'b0;
        tick(2);

        // Full-mask run; ap_start then held high through the chain controller's DONE.
        en = 4'hF; sz = 32'd4096; st = 1'b1;
        tick(1);
        chk("s1_ready", 64'(ifc0.ap_ready), 64'd1);
        chk("s1_chs", 64'(ifc0.ch_start), 64'hF);
        chk("s1_size", 64'(ifc0.ch_xfer_size_in_bytes), 64'd4096);
        en = 4'h0; sz = 32'd123;
        tick(4); dn = 4'b0001; tick(1); dn = '0;
        tick(3); dn = 4'b0110; tick(1); dn = '0;
        tick(10); dn = 4'b1000; tick(1); dn = '0;
        chk("s1_done_early", 64'(ifc0.ap_done), 64'd0);
        chk("s1_size_held", 64'(ifc0.ch_xfer_size_in_bytes), 64'd4096);
        tick(1);
        chk("s1_done", 64'(ifc0.ap_done), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("chain_hold", 64'(ifc1.ap_done), 64'd1);
            if (i == 1) chk("s1_idle_after", 64'(ifc0.ap_idle), 64'd1);
            if (i == 9) cont = 1'b1;
            tick(1);
        end
        chk("chain_idle", 64'(ifc1.ap_idle), 64'd1);
        chk("chain_done_clr", 64'(ifc1.ap_done), 64'd0);
        chk("hs_no_rerun", 64'(ifc0.ap_idle), 64'd1);
        cont = 1'b0; st = 1'b0;
        tick(1);

        // Masked run with zero size: wrong-channel dones must not complete it.
        en = 4'b0101; sz = '0; st = 1'b1;
        tick(1);
        st = 1'b0;
        chk("s2_size_default", 64'(ifc0.ch_xfer_size_in_bytes), 64'd16384);
        dn = 4'b1010;
        tick(6);
        chk("s2_no_done", 64'(ifc0.ap_done), 64'd0);
        chk("s2_busy", 64'(ifc1.ap_idle), 64'd0);
        dn = 4'b0101; tick(1); dn = '0; tick(1);
        chk("s2_done", 64'(ifc0.ap_done), 64'd1);
        cont = 1'b1;
        tick(3);
        chk("s2_idle_hs", 64'(ifc0.ap_idle), 64'd1);
        chk("s2_idle_chain", 64'(ifc1.ap_idle), 64'd1);
        cont = 1'b0;

        // Empty mask goes straight to DONE.
        en = '0; st = 1'b1;
        tick(1);
        st = 1'b0;
        chk("s3_ready", 64'(ifc0.ap_ready), 64'd1);
        chk("s3_chs", 64'(ifc0.ch_start), 64'd0);
        tick(1);
        chk("s3_done", 64'(ifc0.ap_done), 64'd1);
        cont = 1'b1;
        tick(2);
        chk("s3_idle", 64'(ifc1.ap_idle), 64'd1);
        cont = 1'b0;

        // A second rising edge of ap_start during RUN is dropped.
        r0 = rdy_cnt; d0 = done_cnt;
        en = 4'hF; sz = 32'd64; st = 1'b1;
        tick(1); st = 1'b0;
        tick(2); st = 1'b1;
        tick(2); st = 1'b0;
        tick(1); dn = 4'hF;
        tick(1); dn = '0; cont = 1'b1;
        tick(4);
        chk("s5_one_ready", 64'(rdy_cnt - r0), 64'd1);
        chk("s5_one_done", 64'(done_cnt - d0), 64'd1);
        cont = 1'b0;

        // Asynchronous reset landing in the START cycle.
        en = 4'hF; sz = 32'd256; st = 1'b1;
        tick(1); st = 1'b0;
        #2 areset = 1'b1;
        #1;
        chk("s6_chs", 64'(ifc0.ch_start), 64'd0);
        chk("s6_idle", 64'(ifc0.ap_idle), 64'd1);
        chk("s6_done", 64'(ifc1.ap_done), 64'd0);
`ifdef KRNL_CTRL_PERF_CNT_EN
        chk("s6_perf", ifc0.perf_cycles, 64'd0);
`endif
        #3 areset = 1'b0;
        tick(1);
        en = 4'b0011; st = 1'b1;
        tick(1);
        chk("s6_ready", 64'(ifc0.ap_ready), 64'd1);
        st = 1'b0; dn = 4'b0011;
        tick(1); dn = '0;
        chk("s6_not_done", 64'(ifc0.ap_done), 64'd0);
        tick(1);
        chk("s6_done_after", 64'(ifc0.ap_done), 64'd1);
        cont = 1'b1; tick(2); cont = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            st   = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 9) == 0) ? '0 : NCH'($urandom);
            sz   = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom_range(1, 65536));
            dn   = NCH'($urandom) & NCH'($urandom);
            cont = ($urandom_range(0, 2) == 0);
`ifdef KRNL_CTRL_PERF_CNT_EN
            pclr = ($urandom_range(0, 15) == 0);
`endif
            tick(1);
        end
        st = 1'b0; dn = 4'hF; cont = 1'b1;
`ifdef KRNL_CTRL_PERF_CNT_EN
        pclr = 1'b0;
`endif
        tick(10);
        chk("drain_idle_hs", 64'(ifc0.ap_idle), 64'd1);
        chk("drain_idle_chain", 64'(ifc1.ap_idle), 64'd1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
